// File: rtl/sprite_line_scheduler_if.sv
// Scheduler-side bus bundle: attribute RAM port, pattern RAM port and shifter-slot load port.
// master = scheduler, slave = RAMs plus shifter slots.
interface sprite_line_scheduler_if #(
  parameter int unsigned NUM_SPRITES  = 16,
  parameter int unsigned MAX_PER_LINE = 4
);
  localparam int unsigned ATTR_AW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned SLOT_W  = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

  logic [ATTR_AW-1:0] o_Attr_Addr;
  logic [26:0]        i_Attr_Data;
  logic [9:0]         o_Pat_Addr;
  logic [31:0]        i_Pat_Data;
  logic               o_Slot_Clear;
  logic               o_Slot_Load;
  logic [SLOT_W-1:0]  o_Slot_Idx;
  logic [9:0]         o_Slot_X;
  logic [31:0]        o_Slot_Pixels;

  modport master (
    output o_Attr_Addr,
    input  i_Attr_Data,
    output o_Pat_Addr,
    input  i_Pat_Data,
    output o_Slot_Clear,
    output o_Slot_Load,
    output o_Slot_Idx,
    output o_Slot_X,
    output o_Slot_Pixels
  );

  modport slave (
    input  o_Attr_Addr,
    output i_Attr_Data,
    input  o_Pat_Addr,
    output i_Pat_Data,
    input  o_Slot_Clear,
    input  o_Slot_Load,
    input  o_Slot_Idx,
    input  o_Slot_X,
    input  o_Slot_Pixels
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: at hblank start scans the attribute RAM for sprites covering
// the next row, fetches their pattern rows and loads the shifter slots in index order.
module sprite_line_scheduler #(
  parameter int unsigned NUM_SPRITES  = 16,
  parameter int unsigned MAX_PER_LINE = 4,
  parameter int unsigned SPRITE_H     = 16,
  parameter int unsigned ACTIVE_COLS  = 640,
  parameter int unsigned ACTIVE_ROWS  = 480,
  parameter int unsigned TOTAL_ROWS   = 525
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [9:0]              i_Row,
  input  logic [9:0]              i_Column,
  sprite_line_scheduler_if.master io_Sprite,
  output logic                    o_Busy,
  output logic                    o_Overflow
);

  localparam int unsigned IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned SLOT_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_PER_LINE + 1);
  localparam int unsigned RIS_W  = $clog2(SPRITE_H);
  localparam int unsigned PAT_W  = 10 - RIS_W;
  localparam int unsigned ROW_W  = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTR,
    S_CHECK,
    S_FETCH,
    S_LOAD
  } state_t;

  state_t              r_State, w_State_Nxt;
  logic [IDX_W-1:0]    r_Idx, w_Idx_Nxt;
  logic [CNT_W-1:0]    r_Count, w_Count_Nxt;
  logic [ROW_W-1:0]    r_Row, w_Row_Nxt;
  logic [9:0]          r_X, w_X_Nxt;
  logic [9:0]          r_Pat_Addr, w_Pat_Addr_Nxt;
  logic                r_Slot_Clear, w_Slot_Clear_Nxt;
  logic                r_Slot_Load, w_Slot_Load_Nxt;
  logic [SLOT_W-1:0]   r_Slot_Idx, w_Slot_Idx_Nxt;
  logic [9:0]          r_Slot_X, w_Slot_X_Nxt;
  logic [31:0]         r_Slot_Pixels, w_Slot_Pixels_Nxt;
  logic                r_Busy, w_Busy_Nxt;
  logic                r_Overflow, w_Overflow_Nxt;

  logic [ROW_W-1:0]    w_Next_Row;
  logic                w_Trigger;
  logic                w_Attr_En;
  logic [ROW_W-1:0]    w_Attr_Y;
  logic [9:0]          w_Attr_X;
  logic [PAT_W-1:0]    w_Attr_Pat;
  logic [ROW_W-1:0]    w_Diff;
  logic                w_Hit;
  logic                w_Last_Idx;
  logic                w_Slot_Free;

  // Row after the current one, wrapping at the bottom of the frame
  assign w_Next_Row = (i_Row == ROW_W'(TOTAL_ROWS - 1)) ? '0 : ROW_W'(i_Row + ROW_W'(1));
  assign w_Trigger  = (i_Column == 10'(ACTIVE_COLS)) && (w_Next_Row < ROW_W'(ACTIVE_ROWS));

  assign w_Attr_En  = io_Sprite.i_Attr_Data[26];
  assign w_Attr_Y   = io_Sprite.i_Attr_Data[25:16];
  assign w_Attr_X   = io_Sprite.i_Attr_Data[15:6];
  assign w_Attr_Pat = io_Sprite.i_Attr_Data[PAT_W-1:0];

  // Modulo-1024 difference: sprites starting below the row wrap to a large value and miss
  assign w_Diff      = ROW_W'(r_Row - w_Attr_Y);
  assign w_Hit       = w_Attr_En && (w_Diff < ROW_W'(SPRITE_H));
  assign w_Last_Idx  = (r_Idx == IDX_W'(NUM_SPRITES - 1));
  assign w_Slot_Free = (r_Count < CNT_W'(MAX_PER_LINE));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State       <= S_IDLE;
      r_Idx         <= '0;
      r_Count       <= '0;
      r_Row         <= '0;
      r_X           <= '0;
      r_Pat_Addr    <= '0;
      r_Slot_Clear  <= 1'b0;
      r_Slot_Load   <= 1'b0;
      r_Slot_Idx    <= '0;
      r_Slot_X      <= '0;
      r_Slot_Pixels <= '0;
      r_Busy        <= 1'b0;
      r_Overflow    <= 1'b0;
    end else begin
      r_State       <= w_State_Nxt;
      r_Idx         <= w_Idx_Nxt;
      r_Count       <= w_Count_Nxt;
      r_Row         <= w_Row_Nxt;
      r_X           <= w_X_Nxt;
      r_Pat_Addr    <= w_Pat_Addr_Nxt;
      r_Slot_Clear  <= w_Slot_Clear_Nxt;
      r_Slot_Load   <= w_Slot_Load_Nxt;
      r_Slot_Idx    <= w_Slot_Idx_Nxt;
      r_Slot_X      <= w_Slot_X_Nxt;
      r_Slot_Pixels <= w_Slot_Pixels_Nxt;
      r_Busy        <= w_Busy_Nxt;
      r_Overflow    <= w_Overflow_Nxt;
    end
  end

  // Scan sequencing; the attribute address is r_Idx itself, so it is presented during ATTR
  always_comb begin
    w_State_Nxt       = r_State;
    w_Idx_Nxt         = r_Idx;
    w_Count_Nxt       = r_Count;
    w_Row_Nxt         = r_Row;
    w_X_Nxt           = r_X;
    w_Pat_Addr_Nxt    = r_Pat_Addr;
    w_Slot_Clear_Nxt  = 1'b0;
    w_Slot_Load_Nxt   = 1'b0;
    w_Slot_Idx_Nxt    = r_Slot_Idx;
    w_Slot_X_Nxt      = r_Slot_X;
    w_Slot_Pixels_Nxt = r_Slot_Pixels;
    w_Overflow_Nxt    = r_Overflow;

    case (r_State)
      S_IDLE: begin
        if (w_Trigger) begin
          w_Row_Nxt        = w_Next_Row;
          w_Slot_Clear_Nxt = 1'b1;
          w_Overflow_Nxt   = 1'b0;
          w_Count_Nxt      = '0;
          w_Idx_Nxt        = '0;
          w_State_Nxt      = S_ATTR;
        end
      end
      S_ATTR: begin
        w_State_Nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_Hit) begin
          if (w_Slot_Free) begin
            w_X_Nxt        = w_Attr_X;
            w_Pat_Addr_Nxt = {w_Attr_Pat, w_Diff[RIS_W-1:0]};
            w_State_Nxt    = S_FETCH;
          end else begin
            w_Overflow_Nxt = 1'b1;
            w_State_Nxt    = S_IDLE;
          end
        end else if (w_Last_Idx) begin
          w_State_Nxt = S_IDLE;
        end else begin
          w_Idx_Nxt   = IDX_W'(r_Idx + IDX_W'(1));
          w_State_Nxt = S_ATTR;
        end
      end
      S_FETCH: begin
        w_State_Nxt = S_LOAD;
      end
      S_LOAD: begin
        w_Slot_Load_Nxt   = 1'b1;
        w_Slot_Idx_Nxt    = r_Count[SLOT_W-1:0];
        w_Slot_X_Nxt      = r_X;
        w_Slot_Pixels_Nxt = io_Sprite.i_Pat_Data;
        w_Count_Nxt       = CNT_W'(r_Count + CNT_W'(1));
        if (w_Last_Idx) begin
          w_State_Nxt = S_IDLE;
        end else begin
          w_Idx_Nxt   = IDX_W'(r_Idx + IDX_W'(1));
          w_State_Nxt = S_ATTR;
        end
      end
      default: begin
        w_State_Nxt = S_IDLE;
      end
    endcase

    w_Busy_Nxt = (w_State_Nxt != S_IDLE);
  end

  assign io_Sprite.o_Attr_Addr   = r_Idx;
  assign io_Sprite.o_Pat_Addr    = r_Pat_Addr;
  assign io_Sprite.o_Slot_Clear  = r_Slot_Clear;
  assign io_Sprite.o_Slot_Load   = r_Slot_Load;
  assign io_Sprite.o_Slot_Idx    = r_Slot_Idx;
  assign io_Sprite.o_Slot_X      = r_Slot_X;
  assign io_Sprite.o_Slot_Pixels = r_Slot_Pixels;
  assign o_Busy                  = r_Busy;
  assign o_Overflow              = r_Overflow;

endmodule
